// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store unit for a five-stage pipeline. It decodes the load or
// store in InstrM, runs a single request/ack handshake on the data-memory bus,
// aligns and extends load data, and stalls the pipeline while the access is in
// flight. A watchdog counter ends any access that is never acknowledged.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-low
//   ALUResultM  in   [31:0] effective byte address
//   WriteDataM  in   [31:0] store source data (rs2)
//   InstrM      in   [31:0] MEM-stage instruction (opcode/funct3 decoded here)
//   dmem_req    out  request, held high for the whole access
//   dmem_we     out  1 = store, 0 = load
//   dmem_addr   out  [31:0] word-aligned address
//   dmem_be     out  [3:0] byte enables
//   dmem_wdata  out  [31:0] lane-replicated store data
//   dmem_ack    in   one-cycle completion strobe (rdata valid alongside)
//   dmem_rdata  in   [31:0] raw read word
//   ReadDataM   out  [31:0] extended load result (registered)
//   MemStallM   out  pipeline hold for IF..MEM registers (combinational)
//   MemFaultM   out  [1:0] 00 none, 01 misaligned, 10 bus timeout, 11 bad funct3
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] InstrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic [1:0]  MemFaultM
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [1:0] FaultNone     = 2'b00;
  localparam logic [1:0] FaultMisalign = 2'b01;
  localparam logic [1:0] FaultTimeout  = 2'b10;
  localparam logic [1:0] FaultFunct3   = 2'b11;

  // Counter only has to reach TIMEOUT-1: the last BUSY cycle is the one in
  // which the counter already holds TIMEOUT-1.
  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Instruction decode (IDLE-state view of InstrM)
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] offset;
  logic       is_load;
  logic       is_store;
  logic       is_mem;
  logic       f3_legal;
  logic       misaligned;
  logic [3:0] be_new;
  logic [31:0] wdata_new;

  assign opcode   = InstrM[6:0];
  assign funct3   = InstrM[14:12];
  assign offset   = ALUResultM[1:0];
  assign is_load  = (opcode == OpLoad);
  assign is_store = (opcode == OpStore);
  assign is_mem   = is_load | is_store;

  // Remaining instruction bits carry no meaning for this unit.
  logic unused_instr;
  assign unused_instr = ^{InstrM[31:15], InstrM[11:7]};

  // Loads accept lb/lh/lw/lbu/lhu, stores sb/sh/sw. A load with an undefined
  // funct3 is reported the same way as a store with one.
  always_comb begin
    f3_legal = 1'b0;
    unique case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = is_mem;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase
  end

  // funct3[1:0] encodes the access size for every legal encoding:
  // 00 byte, 01 half, 10 word.
  always_comb begin
    misaligned = 1'b0;
    unique case (funct3[1:0])
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = |offset;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = WriteDataM;
    unique case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << offset;
        wdata_new = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << offset;
        wdata_new = {2{WriteDataM[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = WriteDataM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            timeout_q, timeout_d;

  logic start;
  assign start = (state_q == StIdle) & is_mem & f3_legal & ~misaligned;

  // ---------------------------------------------------------------------------
  // Load data alignment and extension, using the latched access shape
  // ---------------------------------------------------------------------------
  logic [31:0] lane;
  logic [31:0] load_ext;

  assign lane = dmem_rdata >> {off_q, 3'b000};

  // funct3[2] set means the unsigned variant (lbu/lhu).
  always_comb begin
    load_ext = lane;
    unique case (f3_q[1:0])
      2'b00:   load_ext = {{24{lane[7] & ~f3_q[2]}}, lane[7:0]};
      2'b01:   load_ext = {{16{lane[15] & ~f3_q[2]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StBusy;
          cnt_d     = '0;
          timeout_d = 1'b0;
          addr_d    = {ALUResultM[31:2], 2'b00};
          be_d      = be_new;
          wdata_d   = wdata_new;
          we_d      = is_store;
          f3_d      = funct3;
          off_d     = offset;
        end
      end

      StBusy: begin
        // An ack in the final permitted cycle still completes normally.
        if (dmem_ack) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d = load_ext;
          end
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        // Single cycle that lets the pipeline advance past the access.
        state_d   = StIdle;
        timeout_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmem_req   = (state_q == StBusy);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign ReadDataM  = rdata_q;

  // Stall and fault are forced quiet while reset is asserted so the pipeline
  // does not see a hold or fault from a state that is about to be discarded.
  assign MemStallM = reset & (start | (state_q == StBusy));

  always_comb begin
    MemFaultM = FaultNone;
    if (reset) begin
      if ((state_q == StIdle) && is_mem) begin
        if (!f3_legal) begin
          MemFaultM = FaultFunct3;
        end else if (misaligned) begin
          MemFaultM = FaultMisalign;
        end
      end else if ((state_q == StDone) && timeout_q) begin
        MemFaultM = FaultTimeout;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Scoreboard bench: the driver issues directed and random accesses, computing
// the expected bus request, completion result, IDLE faults and per-cycle
// stall/request levels from a byte-level model, and queues them. The monitor
// samples on the falling edge and pops/compares whenever the DUT shows a
// matching event.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] InstrM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic [1:0]  MemFaultM;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .InstrM     (InstrM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .ReadDataM  (ReadDataM),
    .MemStallM  (MemStallM),
    .MemFaultM  (MemFaultM)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [1:0]  fault;
    logic [31:0] rdata;
  } res_t;

  typedef struct packed {
    logic stall;
    logic req;
  } cyc_t;

  req_t       req_q[$];
  res_t       res_q[$];
  logic [1:0] fault_q[$];
  cyc_t       cyc_q[$];

  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] rd_model = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit legal(input bit ld, input logic [2:0] f3);
    if (ld) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return f3 <= 3'd2;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    int          n;
    logic [63:0] mask;
    logic [31:0] v;
    n    = 1 << f3[1:0];
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = (w >> (8 * off)) & mask[31:0];
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask[31:0];
    return v;
  endfunction

  function automatic logic [31:0] store_val(input int n, input logic [31:0] wd);
    if (n == 1) return (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit st, input bit rq);
    cyc_t c;
    c.stall = st;
    c.req   = rq;
    cyc_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int dly, input bit no_ack,
                       input logic [31:0] rdata);
    bit   ld, st;
    int   n, nb;
    req_t r;
    res_t e;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    InstrM     = ($urandom() & 32'hFFFF_8F80) | {17'b0, f3, 5'b0, op};
    ALUResultM = addr;
    WriteDataM = wd;
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom();
    if (!ld && !st) begin
      step(1'b0, 1'b0);
      return;
    end
    if (!legal(ld, f3)) begin
      fault_q.push_back(2'b11);
      step(1'b0, 1'b0);
      return;
    end
    n = 1 << f3[1:0];
    if ((int'(addr[1:0]) % n) != 0) begin
      fault_q.push_back(2'b01);
      step(1'b0, 1'b0);
      return;
    end
    r.we    = st;
    r.addr  = addr & 32'hFFFF_FFFC;
    r.be    = 4'(((1 << n) - 1) << addr[1:0]);
    r.wdata = store_val(n, wd);
    req_q.push_back(r);
    step(1'b1, 1'b0);
    nb = no_ack ? int'(TIMEOUT) : dly + 1;
    for (int i = 0; i < nb; i++) begin
      dmem_ack   = !no_ack && (i == nb - 1);
      dmem_rdata = dmem_ack ? rdata : $urandom();
      step(1'b1, 1'b1);
    end
    if (ld) rd_model = no_ack ? 32'h0 : load_val(f3, addr[1:0], rdata);
    e.fault = no_ack ? 2'b10 : 2'b00;
    e.rdata = rd_model;
    res_q.push_back(e);
    // Completion cycle: bus noise and an arbitrary instruction must be ignored.
    InstrM     = $urandom();
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom();
    step(1'b0, 1'b0);
    dmem_ack = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit         prev_req;
    bit         have_cur;
    req_t       cur;
    cyc_t       c;
    res_t       e;
    logic [1:0] f;
    prev_req = 1'b0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_req = 1'b0;
      end else begin
        if (cyc_q.size() == 0) begin
          fail_evt("cycle", "DUT cycle with no expectation queued");
        end else begin
          c = cyc_q.pop_front();
          chk("MemStallM", 32'(MemStallM), 32'(c.stall));
          chk("dmem_req", 32'(dmem_req), 32'(c.req));
        end
        if (dmem_req && !prev_req) begin
          if (req_q.size() == 0) begin
            fail_evt("req_start", "request issued while none expected");
            have_cur = 1'b0;
          end else begin
            cur      = req_q.pop_front();
            have_cur = 1'b1;
            chk("req_we", 32'(dmem_we), 32'(cur.we));
            chk("req_addr", dmem_addr, cur.addr);
            chk("req_be", 32'(dmem_be), 32'(cur.be));
            if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
          end
        end else if (dmem_req) begin
          if (have_cur) begin
            chk("busy_addr", dmem_addr, cur.addr);
            chk("busy_be", 32'(dmem_be), 32'(cur.be));
            chk("busy_we", 32'(dmem_we), 32'(cur.we));
            if (cur.we) chk("busy_wdata", dmem_wdata, cur.wdata);
          end
        end else if (prev_req) begin
          if (res_q.size() == 0) begin
            fail_evt("done", "completion with none expected");
          end else begin
            e = res_q.pop_front();
            chk("done_fault", 32'(MemFaultM), 32'(e.fault));
            chk("ReadDataM", ReadDataM, e.rdata);
          end
        end else if (MemFaultM != 2'b00) begin
          if (fault_q.size() == 0) begin
            fail_evt("idle_fault", "fault raised while none expected");
          end else begin
            f = fault_q.pop_front();
            chk("idle_fault", 32'(MemFaultM), 32'(f));
          end
        end
        prev_req = dmem_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sel, dly, n;
    bit          no_ack;

    reset      = 1'b0;
    InstrM     = 32'h0000_2003;  // lw, held during reset
    ALUResultM = 32'h0000_0100;
    WriteDataM = 32'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", 32'(MemStallM), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    ALUResultM = 32'h0000_0101;  // misaligned lw: fault must stay quiet in reset
    @(negedge clk);
    chk("rst_fault", 32'(MemFaultM), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    InstrM = 32'h0000_0013;
    mon_en = 1'b1;

    // Directed cases
    do_op(OP_LOAD, 3'b010, 32'h0000_0100, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);
    do_op(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0, 0, 1'b0, 32'h8011_2233);
    do_op(OP_LOAD, 3'b100, 32'h0000_0103, 32'h0, 0, 1'b0, 32'h8011_2233);
    do_op(OP_STORE, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 2, 1'b0, 32'h0);
    do_op(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0, 0, 1'b0, 32'h0);
    do_op(OP_STORE, 3'b011, 32'h0000_0200, 32'h1234_5678, 0, 1'b0, 32'h0);
    do_op(OP_LOAD, 3'b110, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h0);
    do_op(7'b0110011, 3'b000, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h0);
    do_op(OP_LOAD, 3'b010, 32'h0000_0104, 32'h0, 0, 1'b1, 32'h0);
    do_op(OP_LOAD, 3'b101, 32'h0000_0106, 32'h0, TIMEOUT - 1, 1'b0, 32'h9876_5432);

    // Reset in the middle of an access, then a late ack
    mon_en     = 1'b0;
    InstrM     = 32'h0000_2003;
    ALUResultM = 32'h0000_0300;
    dmem_ack   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstb_req_busy", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    InstrM = 32'h0000_0013;
    @(negedge clk);
    chk("rstb_stall", 32'(MemStallM), 32'd0);
    chk("rstb_fault", 32'(MemFaultM), 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rstb_req_after", 32'(dmem_req), 32'd0);
    chk("rstb_rdata", ReadDataM, 32'h0);
    chk("rstb_stall_after", 32'(MemStallM), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rstb_late_ack", ReadDataM, 32'h0);
    chk("rstb_req_idle", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    rd_model = 32'h0;
    mon_en   = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? OP_LOAD : (sel < 9) ? OP_STORE : 7'($urandom());
      f3  = 3'($urandom_range(0, 7));
      n   = 1 << f3[1:0];
      addr = $urandom();
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
      sel = $urandom_range(0, 5);
      dly = (sel == 0) ? 0 : (sel == 1) ? int'(TIMEOUT) - 1 : $urandom_range(0, TIMEOUT - 1);
      no_ack = (op == OP_LOAD) && ($urandom_range(0, 9) == 0);
      do_op(op, f3, addr, $urandom(), dly, no_ack, $urandom());
    end

    InstrM = 32'h0000_0013;
    repeat (3) step(1'b0, 1'b0);
    chk("left_req", 32'(req_q.size()), 32'd0);
    chk("left_res", 32'(res_q.size()), 32'd0);
    chk("left_fault", 32'(fault_q.size()), 32'd0);
    chk("left_cyc", 32'(cyc_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
